// File: rtl/i2c_pad_conditioner.sv
// I2C pad conditioner: open-drain output combine, input synchronization and
// glitch filtering, START/STOP detection, bus-busy tracking and an SCL
// stuck-low timeout with a sticky flag.
module i2c_pad_conditioner #(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned TO_W       = 20
) (
    input  logic            PCLK,
    input  logic            PRESETn,
    input  logic            ctl_scl_o,
    input  logic            ctl_scl_oen_o,
    input  logic            ctl_sda_o,
    input  logic            ctl_sda_oen_o,
    output logic            ctl_scl_i,
    output logic            ctl_sda_i,
    input  logic            scl_pad_i,
    input  logic            sda_pad_i,
    output logic            scl_pad_o,
    output logic            scl_pad_oen_o,
    output logic            sda_pad_o,
    output logic            sda_pad_oen_o,
    input  logic            timeout_en,
    input  logic [TO_W-1:0] timeout_limit,
    input  logic            stuck_clr,
    output logic            start_det,
    output logic            stop_det,
    output logic            bus_busy,
    output logic            scl_stuck
);

    localparam int unsigned CW = $clog2(FILTER_LEN) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

    // Bit 0 carries SCL, bit 1 carries SDA.
    logic [1:0]      pad_raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      filt;
    logic [1:0]      filt_prev;
    logic [CW-1:0]   cnt [2];
    logic [TO_W-1:0] tcnt;

    logic scl_f, sda_f, scl_prev, sda_prev;
    logic start_cond, stop_cond;
    logic tcnt_run, stuck_set;

    // Open-drain: pad pulled low only when enabled and driving 0.
    assign scl_pad_o     = 1'b0;
    assign sda_pad_o     = 1'b0;
    assign scl_pad_oen_o = ctl_scl_oen_o | ctl_scl_o;
    assign sda_pad_oen_o = ctl_sda_oen_o | ctl_sda_o;

    assign pad_raw   = {sda_pad_i, scl_pad_i};
    assign scl_f     = filt[0];
    assign sda_f     = filt[1];
    assign scl_prev  = filt_prev[0];
    assign sda_prev  = filt_prev[1];
    assign ctl_scl_i = scl_f;
    assign ctl_sda_i = sda_f;

    // SDA edges only count as START/STOP when SCL stayed high across the edge.
    assign start_cond = scl_prev & scl_f & sda_prev & ~sda_f;
    assign stop_cond  = scl_prev & scl_f & ~sda_prev & sda_f;

    assign tcnt_run  = timeout_en && (timeout_limit != '0) && !scl_f;
    assign stuck_set = tcnt_run && (tcnt == timeout_limit - TO_W'(1));

    // Two-flop synchronizer for the asynchronous pad inputs.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= pad_raw;
            sync2 <= sync1;
        end
    end

    // Stability filter: follow the synchronized level only after FILTER_LEN
    // consecutive differing cycles; any agreement restarts the count.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            filt <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Bus events and busy tracking; a stuck set overrides a coincident START.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            filt_prev <= 2'b11;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            bus_busy  <= 1'b0;
        end else begin
            filt_prev <= filt;
            start_det <= start_cond;
            stop_det  <= stop_cond;
            if (stuck_set || stop_cond) begin
                bus_busy <= 1'b0;
            end else if (start_cond) begin
                bus_busy <= 1'b1;
            end
        end
    end

    // SCL-low timeout; the counter keeps running after a trip so the flag
    // cannot re-trigger until SCL goes high again.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tcnt      <= '0;
            scl_stuck <= 1'b0;
        end else begin
            if (!tcnt_run) begin
                tcnt <= '0;
            end else if (tcnt != '1) begin
                tcnt <= tcnt + TO_W'(1);
            end
            if (stuck_set) begin
                scl_stuck <= 1'b1;
            end else if (stuck_clr) begin
                scl_stuck <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2c_pad_conditioner.sv
// Directed testbench for i2c_pad_conditioner (FILTER_LEN=4, TO_W=8).
module tb_i2c_pad_conditioner;

    localparam int unsigned TO_W = 8;

    logic            PCLK = 1'b0;
    logic            PRESETn;
    logic            ctl_scl_o, ctl_scl_oen_o, ctl_sda_o, ctl_sda_oen_o;
    logic            ctl_scl_i, ctl_sda_i;
    logic            scl_pad_i, sda_pad_i;
    logic            scl_pad_o, scl_pad_oen_o, sda_pad_o, sda_pad_oen_o;
    logic            timeout_en;
    logic [TO_W-1:0] timeout_limit;
    logic            stuck_clr;
    logic            start_det, stop_det, bus_busy, scl_stuck;

    int total = 0;
    int bad   = 0;

    i2c_pad_conditioner #(
        .FILTER_LEN(4),
        .TO_W      (TO_W)
    ) dut (
        .PCLK         (PCLK),
        .PRESETn      (PRESETn),
        .ctl_scl_o    (ctl_scl_o),
        .ctl_scl_oen_o(ctl_scl_oen_o),
        .ctl_sda_o    (ctl_sda_o),
        .ctl_sda_oen_o(ctl_sda_oen_o),
        .ctl_scl_i    (ctl_scl_i),
        .ctl_sda_i    (ctl_sda_i),
        .scl_pad_i    (scl_pad_i),
        .sda_pad_i    (sda_pad_i),
        .scl_pad_o    (scl_pad_o),
        .scl_pad_oen_o(scl_pad_oen_o),
        .sda_pad_o    (sda_pad_o),
        .sda_pad_oen_o(sda_pad_oen_o),
        .timeout_en   (timeout_en),
        .timeout_limit(timeout_limit),
        .stuck_clr    (stuck_clr),
        .start_det    (start_det),
        .stop_det     (stop_det),
        .bus_busy     (bus_busy),
        .scl_stuck    (scl_stuck)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_scl_i"}, ctl_scl_i, 1'b1);
        check({tag, "_sda_i"}, ctl_sda_i, 1'b1);
        check({tag, "_start"}, start_det, 1'b0);
        check({tag, "_stop"}, stop_det, 1'b0);
        check({tag, "_busy"}, bus_busy, 1'b0);
        check({tag, "_stuck"}, scl_stuck, 1'b0);
    endtask

    initial begin
        PRESETn       = 1'b0;
        ctl_scl_o     = 1'b1;
        ctl_scl_oen_o = 1'b1;
        ctl_sda_o     = 1'b1;
        ctl_sda_oen_o = 1'b1;
        scl_pad_i     = 1'b1;
        sda_pad_i     = 1'b1;
        timeout_en    = 1'b0;
        timeout_limit = '0;
        stuck_clr     = 1'b0;

        // Reset state, during and after reset
        tick(3);
        check_reset_outputs("in_reset");
        PRESETn = 1'b1;
        tick(3);
        check_reset_outputs("after_reset");

        // Open-drain combine
        ctl_sda_oen_o = 1'b0;
        ctl_sda_o     = 1'b0;
        #1;
        check("sda_oen_drive0", sda_pad_oen_o, 1'b0);
        check("sda_pad_o", sda_pad_o, 1'b0);
        ctl_sda_o = 1'b1;
        #1;
        check("sda_oen_drive1", sda_pad_oen_o, 1'b1);
        ctl_scl_oen_o = 1'b0;
        ctl_scl_o     = 1'b0;
        #1;
        check("scl_oen_drive0", scl_pad_oen_o, 1'b0);
        check("scl_pad_o", scl_pad_o, 1'b0);
        ctl_scl_oen_o = 1'b1;
        #1;
        check("scl_oen_released", scl_pad_oen_o, 1'b1);
        ctl_sda_oen_o = 1'b1;

        // 3-cycle SDA glitch is rejected
        sda_pad_i = 1'b0;
        tick(3);
        sda_pad_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("glitch_sda_i", ctl_sda_i, 1'b1);
            check("glitch_no_start", start_det, 1'b0);
        end

        // Filter latency: SDA falls before edge k, filtered at edge k+5 -> START
        sda_pad_i = 1'b0;
        tick(5);
        check("lat_sda_k4", ctl_sda_i, 1'b1);
        tick(1);
        check("lat_sda_k5", ctl_sda_i, 1'b0);
        check("start_not_yet", start_det, 1'b0);
        tick(1);
        check("start_pulse", start_det, 1'b1);
        check("busy_set", bus_busy, 1'b1);
        tick(1);
        check("start_one_cycle", start_det, 1'b0);
        check("busy_held", bus_busy, 1'b1);

        // STOP
        sda_pad_i = 1'b1;
        tick(6);
        check("stop_filt", ctl_sda_i, 1'b1);
        check("stop_not_yet", stop_det, 1'b0);
        tick(1);
        check("stop_pulse", stop_det, 1'b1);
        check("busy_clr", bus_busy, 1'b0);
        tick(1);
        check("stop_one_cycle", stop_det, 1'b0);

        // SDA toggling while SCL low gives no events
        scl_pad_i = 1'b0;
        tick(8);
        check("scl_low_filt", ctl_scl_i, 1'b0);
        sda_pad_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) sda_pad_i = 1'b1;
            tick(1);
            check("sclow_no_start", start_det, 1'b0);
            check("sclow_no_stop", stop_det, 1'b0);
        end
        scl_pad_i = 1'b1;
        tick(8);
        check("sclow_busy", bus_busy, 1'b0);

        // Timeout: START, then SCL held low with limit 100
        sda_pad_i = 1'b0;
        tick(8);
        check("to_busy", bus_busy, 1'b1);
        timeout_en    = 1'b1;
        timeout_limit = 8'd100;
        scl_pad_i     = 1'b0;
        tick(105);
        check("to_stuck_99", scl_stuck, 1'b0);
        check("to_busy_99", bus_busy, 1'b1);
        tick(1);
        check("to_stuck_100", scl_stuck, 1'b1);
        check("to_busy_drop", bus_busy, 1'b0);
        stuck_clr = 1'b1;
        tick(1);
        stuck_clr = 1'b0;
        check("to_clr", scl_stuck, 1'b0);
        tick(150);
        check("to_no_retrigger", scl_stuck, 1'b0);

        // New low period; clear coincident with set -> set wins
        scl_pad_i = 1'b1;
        tick(8);
        check("to_scl_high", ctl_scl_i, 1'b1);
        scl_pad_i = 1'b0;
        tick(105);
        check("coll_before", scl_stuck, 1'b0);
        stuck_clr = 1'b1;
        tick(1);
        stuck_clr = 1'b0;
        check("coll_set_wins", scl_stuck, 1'b1);
        stuck_clr = 1'b1;
        tick(1);
        stuck_clr = 1'b0;
        check("coll_then_clr", scl_stuck, 1'b0);

        // timeout_limit = 0 disables the timeout
        scl_pad_i = 1'b1;
        tick(8);
        timeout_limit = '0;
        scl_pad_i     = 1'b0;
        tick(300);
        check("limit0_no_stuck", scl_stuck, 1'b0);

        // Reset mid-operation with bus busy and tcnt = 50
        scl_pad_i = 1'b1;
        tick(8);
        sda_pad_i = 1'b1;
        tick(8);
        sda_pad_i = 1'b0;
        tick(8);
        check("mid_busy", bus_busy, 1'b1);
        timeout_limit = 8'd100;
        scl_pad_i     = 1'b0;
        tick(56);
        check("mid_scl_low", ctl_scl_i, 1'b0);
        PRESETn = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        tick(1);
        PRESETn = 1'b1;
        tick(105);
        check("mid_stuck_99", scl_stuck, 1'b0);
        check("mid_no_start", bus_busy, 1'b0);
        tick(1);
        check("mid_stuck_100", scl_stuck, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_pad_conditioner.md
# i2c_pad_conditioner

Pad-side conditioning stage between the I2C master controller's open-drain pin signals (scl/sda `_o`/`_oen_o`/`_i`) and the SCL/SDA pads. It combines each controller output and output enable into a single active-low pad enable. Incoming pad levels pass through a 2-FF synchronizer and a stability filter before they reach the controller. From the filtered lines it also derives bus-level status: START/STOP pulses, bus busy, and a sticky SCL stuck-low timeout that the APB interrupt logic can consume.

## Interface
Parameters:
- FILTER_LEN, 4: consecutive cycles a synchronized level must differ from the filtered level before the filtered level follows it; legal range ≥1.
- TO_W, 20: width of the SCL-low timeout counter and of `timeout_limit`.

Ports:
- PCLK  in  1  clock, all state on rising edge.
- PRESETn  in  1  asynchronous, active-low reset.
- ctl_scl_o  in  1  controller SCL output level.
- ctl_scl_oen_o  in  1  controller SCL output enable, active-low (1 = released).
- ctl_sda_o  in  1  controller SDA output level.
- ctl_sda_oen_o  in  1  controller SDA output enable, active-low.
- ctl_scl_i  out  1  filtered SCL to controller.
- ctl_sda_i  out  1  filtered SDA to controller.
- scl_pad_i  in  1  raw SCL pad level, asynchronous.
- sda_pad_i  in  1  raw SDA pad level, asynchronous.
- scl_pad_o  out  1  SCL pad drive value, constant 0.
- scl_pad_oen_o  out  1  SCL pad enable, active-low.
- sda_pad_o  out  1  SDA pad drive value, constant 0.
- sda_pad_oen_o  out  1  SDA pad enable, active-low.
- timeout_en  in  1  enables the SCL-low timeout.
- timeout_limit  in  TO_W  SCL-low cycle count that flags stuck.
- stuck_clr  in  1  clears `scl_stuck`.
- start_det  out  1  one-cycle pulse on START.
- stop_det  out  1  one-cycle pulse on STOP.
- bus_busy  out  1  a START has been seen with no following STOP or timeout.
- scl_stuck  out  1  sticky SCL stuck-low flag.

## Operation
- **Open-drain combine** (combinational, not reset): `x_pad_oen_o = ctl_x_oen_o | ctl_x_o`. The pad is driven low only when the controller enables the output and drives 0. `x_pad_o = 0`.
- **Synchronizer:** per line, registers s1 ← pad, s2 ← s1. Both reset to 1.
- **Filter:** per line, state `filt` (reset 1) and a counter `cnt` (reset 0, width clog2(FILTER_LEN)+1).
  - If s2 == filt: cnt ← 0.
  - Else if cnt == FILTER_LEN-1: filt ← s2 and cnt ← 0.
  - Else: cnt ← cnt+1.
  - `ctl_x_i = filt`.
- **Edge detect:** hold previous filtered values (reset 1).
  - START: sda_f falls while scl_f is 1 in both the previous and current cycle.
  - STOP: sda_f rises under the same SCL condition.
  - start_det and stop_det are registered and assert the cycle after the filtered SDA edge.
- **bus_busy:**
  - Set on START.
  - Cleared on STOP or when scl_stuck sets.
  - A START in the same cycle as a stuck set leaves bus_busy at 0.
- **Timeout counter `tcnt`** (TO_W bits, reset 0):
  - Held at 0 when timeout_en=0, timeout_limit=0, or scl_f=1.
  - Otherwise increments, saturating at all-ones.
  - scl_stuck sets when tcnt == timeout_limit-1 and scl_f=0 (the limit-th low cycle).
  - scl_stuck clears on stuck_clr. If set and clear coincide, set wins.
  - Once stuck, tcnt keeps running or saturating, and does not re-trigger until scl_f returns to 1.

## Timing
- **Reset values:** ctl_scl_i=ctl_sda_i=1, start_det=stop_det=0, bus_busy=0, scl_stuck=0. The pad outputs follow the controller inputs combinationally.
- **Filter latency:** if a pad level changes before edge k and stays stable, s2 shows it after edge k+1 and `filt` updates at edge k+1+FILTER_LEN (k+5 for the default).
- **Glitch rejection:** a level present at s2 for fewer than FILTER_LEN consecutive cycles is rejected; any return to `filt` resets `cnt`.
- **FILTER_LEN=1:** filt follows s2 one cycle later, giving total latency 2 edges after sampling.
- **Detection latency:** start_det/stop_det assert one cycle after the filt edge and last exactly 1 cycle. A START with no STOP in between does not re-set bus_busy; it stays 1.
- **Reset mid-operation:** asserting PRESETn=0 at any time forces all registers to reset values immediately. Any in-progress filter count or timeout is discarded.

## Test plan
- **Reset and open-drain combine:** hold PRESETn=0, then release with pads=1. ctl_scl_i=ctl_sda_i=1, all status outputs 0. Drive ctl_sda_oen_o=0 with ctl_sda_o=0, then 1 → sda_pad_oen_o=0, then 1.
- **Filter latency:** FILTER_LEN=4, drop sda_pad_i to 0 before edge k → ctl_sda_i falls at edge k+5. A 3-cycle low glitch never reaches ctl_sda_i.
- **START/STOP:** with scl=1, sda 1→0 → one start_det pulse, then bus_busy=1. Then sda 0→1 with scl=1 → one stop_det pulse, then bus_busy=0. An SDA toggle while scl=0 → no pulses.
- **Timeout:** timeout_en=1, timeout_limit=100, hold scl_pad_i=0 → scl_stuck rises on the 100th filtered-low cycle and bus_busy drops. Assert stuck_clr while SCL stays low → scl_stuck=0 and stays 0 until SCL goes high and then low for another 100 cycles.
- **Set/clear collision and disable:** stuck_clr asserted in the set cycle → scl_stuck=1. With timeout_limit=0, SCL held low for 2^TO_W cycles → scl_stuck never sets.
- **Reset mid-operation:** assert reset while bus_busy=1 and tcnt=50 → all outputs return to reset values. After release, SCL held low needs a full 100 cycles to set scl_stuck.
